spm_led_uart_tx: RTL and testbench

SPM_LED_UART_TX -- requirements
Module: spm_led_uart_tx

---
 rtl/spm_pkg.sv | 15 +
 rtl/spm_baud_tick.sv | 31 +++
 rtl/spm_led_uart_tx.sv | 116 +++++++++++
 tb/tb_spm_led_uart_tx.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spm_pkg.sv
// Shared definitions for the LED-change UART transmitter: FSM encoding and frame geometry.
package spm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } spm_state_e;

  localparam int SPM_CLKS_PER_BIT = 434;
  localparam int SPM_FRAME_BITS   = 10;
  localparam int SPM_DATA_BITS    = SPM_FRAME_BITS - 2;

endpackage

// File: rtl/spm_baud_tick.sv
// Bit-period tick generator; held cleared while not running so every frame starts on a fresh bit.
module spm_baud_tick
  import spm_pkg::*;
#(
  parameter int CLKS_PER_BIT = SPM_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // 0 marks the first cycle of a bit; reload then count down to terminal count 1.
  assign tick = run && (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (rst || !run || tick) begin
      cnt <= '0;
    end else if (cnt == '0) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/spm_led_uart_tx.sv
// Sends each observed change of the LED byte as a UART 8N1 frame, with a one-deep pending slot.
//   state    | meaning
//   ST_IDLE  | line high, waiting for a change on data_in
//   ST_START | start bit (low)
//   ST_DATA  | eight data bits, LSB first
//   ST_STOP  | stop bit (high); last cycle may chain straight into the next frame
module spm_led_uart_tx
  import spm_pkg::*;
#(
  parameter int CLKS_PER_BIT = SPM_CLKS_PER_BIT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [7:0]  data_in,
  output logic        tx,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic [7:0]  drop_cnt
);

  spm_state_e state;
  logic [7:0] prev;
  logic [7:0] shreg;
  logic [7:0] pend_data;
  logic       pend_vld;
  logic [2:0] bits_left;
  logic       tick;
  logic       change;
  logic       last_stop;

  assign change    = en && (data_in != prev);
  assign last_stop = (state == ST_STOP) && tick;

  spm_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .run  (busy),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      prev      <= 8'h00;
      shreg     <= 8'h00;
      pend_data <= 8'h00;
      pend_vld  <= 1'b0;
      bits_left <= 3'd0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      frame_cnt <= 16'd0;
      drop_cnt  <= 8'h00;
    end else begin
      if (en) prev <= data_in;

      // On the last stop cycle a valid pending byte is consumed, so a new byte refills it without a drop.
      if (change && state != ST_IDLE) begin
        if (!last_stop || pend_vld) pend_data <= data_in;
        if (!last_stop) begin
          pend_vld <= 1'b1;
          if (pend_vld && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
      end else if (last_stop) begin
        pend_vld <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (change) begin
            shreg <= data_in;
            state <= ST_START;
            tx    <= 1'b0;
            busy  <= 1'b1;
          end
        end
        ST_START: begin
          if (tick) begin
            state     <= ST_DATA;
            tx        <= shreg[0];
            bits_left <= 3'(SPM_DATA_BITS - 1);
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bits_left == 3'd0) begin
              state <= ST_STOP;
              tx    <= 1'b1;
            end else begin
              bits_left <= bits_left - 3'd1;
              shreg     <= {1'b0, shreg[7:1]};
              tx        <= shreg[1];
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            frame_cnt <= frame_cnt + 16'd1;
            if (pend_vld || change) begin
              shreg <= pend_vld ? pend_data : data_in;
              state <= ST_START;
              tx    <= 1'b0;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spm_led_uart_tx.sv
// Bench for spm_led_uart_tx: frame-offset reference model checked every cycle, plus a line decoder.
module tb_spm_led_uart_tx;

  localparam int CPB       = 4;
  localparam int FRAME_LEN = 10 * CPB;

  logic        clk;
  logic        rst;
  logic        en;
  logic [7:0]  data_in;
  logic        tx;
  logic        busy;
  logic [15:0] frame_cnt;
  logic [7:0]  drop_cnt;

  spm_led_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .data_in   (data_in),
    .tx        (tx),
    .busy      (busy),
    .frame_cnt (frame_cnt),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ncyc = 0;
  int busy_cycles = 0;

  // reference model: position within the current frame plus pending slot
  bit          m_active;
  int          m_off;
  logic [7:0]  m_byte, m_prev, m_pd;
  bit          m_pv;
  logic [15:0] m_frames;
  logic [7:0]  m_drops;
  logic [7:0]  m_sent_q[$];

  // line decoder
  bit          rx_on;
  int          rx_t;
  logic [7:0]  rx_byte;
  logic [7:0]  rx_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_frame(input logic [7:0] b);
    m_active = 1'b1;
    m_off    = 0;
    m_byte   = b;
    m_sent_q.push_back(b);
  endtask

  task automatic model_step();
    bit chg;
    if (rst) begin
      m_active = 1'b0; m_off = 0; m_prev = 8'h00; m_pv = 1'b0;
      m_frames = 16'd0; m_drops = 8'h00;
      return;
    end
    chg = en && (data_in != m_prev);
    if (en) m_prev = data_in;
    if (!m_active) begin
      if (chg) start_frame(data_in);
    end else if (m_off == FRAME_LEN - 1) begin
      m_frames++;
      if (m_pv) begin
        start_frame(m_pd);
        if (chg) m_pd = data_in;
        else m_pv = 1'b0;
      end else if (chg) begin
        start_frame(data_in);
      end else begin
        m_active = 1'b0;
      end
    end else begin
      m_off++;
      if (chg) begin
        if (m_pv && m_drops != 8'hFF) m_drops++;
        m_pd = data_in;
        m_pv = 1'b1;
      end
    end
  endtask

  function automatic logic exp_tx();
    if (!m_active) return 1'b1;
    if (m_off < CPB) return 1'b0;
    if (m_off < 9 * CPB) return m_byte[(m_off - CPB) / CPB];
    return 1'b1;
  endfunction

  task automatic cyc();
    int idx;
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("tx", tx, exp_tx());
    chk("busy", busy, m_active);
    chk("frame_cnt", frame_cnt, m_frames);
    chk("drop_cnt", drop_cnt, m_drops);
    if (busy) busy_cycles++;
    if (!rx_on) begin
      if (tx == 1'b0) begin rx_on = 1'b1; rx_t = 0; end
    end else begin
      rx_t++;
    end
    if (rx_on && rx_t >= CPB + CPB / 2 && ((rx_t - CPB / 2) % CPB) == 0) begin
      idx = (rx_t - CPB / 2) / CPB;
      if (idx <= 8) rx_byte[idx-1] = tx;
      else begin rx_q.push_back(rx_byte); rx_on = 1'b0; end
    end
    if (rst) rx_on = 1'b0;
    ncyc++;
    if (ncyc > 60000) begin
      $display("FAIL global_timeout: observed %0d cycles expected under 60000", ncyc);
      $fatal(1, "cycle budget exhausted");
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b1; data_in = 8'h00;
    cyc(); cyc();
    rst = 1'b0;
    rx_q.delete(); m_sent_q.delete();
    rx_on = 1'b0; busy_cycles = 0;
  endtask

  task automatic run_until_idle(input string tag, input int limit);
    int n = 0;
    while (busy && n < limit) begin cyc(); n++; end
    chk({tag, "_idle_bound"}, busy, 1'b0);
  endtask

  task automatic wait_off(input string tag, input int off);
    int w = 0;
    while (!(m_active && m_off == off) && w < 200) begin cyc(); w++; end
    chk({tag, "_reach"}, (w < 200), 1'b1);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; data_in = 8'h00;
    m_active = 0; m_off = 0; m_byte = 0; m_prev = 0; m_pd = 0; m_pv = 0;
    m_frames = 0; m_drops = 0; rx_on = 0; rx_t = 0; rx_byte = 0;

    // 1: quiet input
    do_reset();
    for (int i = 0; i < 100; i++) begin
      cyc();
      chk("s1_tx", tx, 1'b1);
      chk("s1_busy", busy, 1'b0);
      chk("s1_frames", frame_cnt, 16'd0);
    end

    // 2: single frame 0xA5
    data_in = 8'hA5;
    cyc();
    run_until_idle("s2", 100);
    chk("s2_busy_cycles", busy_cycles, 40);
    chk("s2_frames", frame_cnt, 16'd1);
    chk("s2_rx_count", rx_q.size(), 1);
    if (rx_q.size() > 0) chk("s2_rx_byte", rx_q[0], 8'hA5);

    // 3: overwrite of pending, back-to-back second frame
    do_reset();
    data_in = 8'h10; cyc();
    repeat (6) cyc();
    data_in = 8'h11; cyc();
    repeat (6) cyc();
    data_in = 8'h12;
    cyc();
    run_until_idle("s3", 200);
    chk("s3_drops", drop_cnt, 8'd1);
    chk("s3_frames", frame_cnt, 16'd2);
    chk("s3_busy_cycles", busy_cycles, 80);
    chk("s3_rx_count", rx_q.size(), 2);
    if (rx_q.size() > 1) begin
      chk("s3_rx0", rx_q[0], 8'h10);
      chk("s3_rx1", rx_q[1], 8'h12);
    end

    // 4: reset on 5th cycle of DATA (counters nonzero beforehand)
    data_in = 8'h5A; cyc();
    wait_off("s4", CPB + 4);
    rst = 1'b1; data_in = 8'h00;
    cyc();
    chk("s4_tx", tx, 1'b1);
    chk("s4_busy", busy, 1'b0);
    chk("s4_frames", frame_cnt, 16'd0);
    chk("s4_drops", drop_cnt, 8'd0);
    rst = 1'b0; busy_cycles = 0; rx_q.delete();
    repeat (60) cyc();
    chk("s4_no_resume", busy_cycles, 0);

    // 5: en low while data toggles
    do_reset();
    en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      data_in = (i % 2 == 0) ? 8'hFF : 8'h00;
      cyc();
    end
    chk("s5_no_frame", busy_cycles, 0);
    en = 1'b1; data_in = 8'hFF;
    cyc();
    run_until_idle("s5", 100);
    chk("s5_frames", frame_cnt, 16'd1);
    chk("s5_rx_count", rx_q.size(), 1);
    if (rx_q.size() > 0) chk("s5_rx_byte", rx_q[0], 8'hFF);

    // 6: change lands on the last STOP cycle while pending is full
    do_reset();
    data_in = 8'h11; cyc();
    repeat (5) cyc();
    data_in = 8'h22; cyc();
    wait_off("s6", FRAME_LEN - 1);
    data_in = 8'h33;
    cyc();
    run_until_idle("s6", 200);
    chk("s6_drops", drop_cnt, 8'd0);
    chk("s6_frames", frame_cnt, 16'd3);
    chk("s6_rx_count", rx_q.size(), 3);
    if (rx_q.size() > 2) begin
      chk("s6_rx0", rx_q[0], 8'h11);
      chk("s6_rx1", rx_q[1], 8'h22);
      chk("s6_rx2", rx_q[2], 8'h33);
    end

    // drop counter saturation
    do_reset();
    for (int i = 0; i < 400; i++) begin
      data_in = data_in + 8'd1;
      cyc();
    end
    chk("sat_drops", drop_cnt, 8'hFF);
    run_until_idle("sat", 200);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 24) == 0) data_in = 8'($urandom);
      en = ($urandom_range(0, 9) != 0);
      cyc();
    end
    en = 1'b1;
    cyc();
    run_until_idle("rnd", 200);
    chk("rnd_rx_count", rx_q.size(), m_sent_q.size());
    for (int i = 0; i < rx_q.size() && i < m_sent_q.size(); i++) begin
      chk("rnd_rx_byte", rx_q[i], m_sent_q[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
